// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and sizing helpers for the fifo_rd_stream drain stage.
package fifo_rd_stream_pkg;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned BUF_IDX_W = 1;
    localparam int unsigned STAT_W    = 32;

    typedef logic [1:0] occ_t;

    // Beat counter width: clog2(pkt_len), never narrower than one bit.
    function automatic int unsigned beat_width(input int unsigned pkt_len);
        return (pkt_len > 1) ? unsigned'($clog2(pkt_len)) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: head/tail ring with occupancy, presenting the head
// entry on a valid/ready stream.
module stream_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output occ_t                  occ,
    output logic                  accept_c
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last_hint;
    } entry_t;

    entry_t                 mem_q [BUF_DEPTH];
    entry_t                 mem_d [BUF_DEPTH];
    logic [BUF_IDX_W-1:0]   head_q, head_d;
    logic [BUF_IDX_W-1:0]   tail_q, tail_d;
    occ_t                   occ_q, occ_d;

    // Ring update; flush empties the ring without touching stored words.
    always_comb begin
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        accept_c = (occ_q != '0) && out_ready;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                mem_d[tail_q].data      = push_data;
                mem_d[tail_q].last_hint = push_last;
                tail_d                  = tail_q + BUF_IDX_W'(1);
            end
            if (accept_c) begin
                head_d = head_q + BUF_IDX_W'(1);
            end
            occ_d = occ_q + occ_t'(push) - occ_t'(accept_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign out_data  = mem_q[head_q].data;
    assign out_valid = (occ_q != '0);
    assign out_last  = out_valid && mem_q[head_q].last_hint;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind async_fifo: pop rule, stale-pop guard, packet
// framing. Define FIFO_RD_STREAM_STATS_EN to add beat/stall counters.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [STAT_W-1:0]     beat_count,
    output logic [STAT_W-1:0]     stall_count
`endif
);

    localparam int unsigned       BEAT_W    = beat_width(PKT_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic              run_q, run_d;
    logic              guard_q, guard_d;
    logic [BEAT_W-1:0] beat_q, beat_d, beat_next;
    logic              push_last;
    logic              accept_c;
    occ_t              occ;

    // Pop only from registered state and FIFO flags; out_ready never reaches rd_en.
    always_comb begin
        run_d      = 1'b1;
        fifo_rd_en = run_q && !fifo_empty && !guard_q
                     && (occ < occ_t'(BUF_DEPTH)) && !flush;
        guard_d    = fifo_rd_en && fifo_almost_empty;
        beat_next  = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        beat_d     = beat_q;
        if (flush) begin
            beat_d = '0;
        end else if (accept_c) begin
            beat_d = beat_next;
        end
        // Tail word sits occ beats behind the head, and occ is at most 1 on a pop.
        push_last = (occ == '0) ? (beat_q == BEAT_LAST) : (beat_next == BEAT_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            guard_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            run_q   <= run_d;
            guard_q <= guard_d;
            beat_q  <= beat_d;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset_n),
        .flush     (flush),
        .push      (fifo_rd_en),
        .push_data (fifo_data),
        .push_last (push_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .occ       (occ),
        .accept_c  (accept_c)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STAT_W-1:0] beat_count_q, beat_count_d;
    logic [STAT_W-1:0] stall_count_q, stall_count_d;

    // Saturating counters; flush deliberately leaves them alone.
    always_comb begin
        beat_count_d  = beat_count_q;
        stall_count_d = stall_count_q;
        if (accept_c && (beat_count_q != '1)) begin
            beat_count_d = beat_count_q + STAT_W'(1);
        end
        if (out_valid && !out_ready && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            beat_count_q  <= beat_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign beat_count  = beat_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO and stream model
// compared every cycle, plus directed literal checks per scenario.
module tb_fifo_rd_stream;

    localparam int DW = 32;
    localparam int P  = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic          fifo_rd_en;
    logic          flush;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]   beat_count;
    logic [31:0]   stall_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (P)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .flush             (flush),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .beat_count        (beat_count),
        .stall_count       (stall_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];
    logic          empty_r;
    logic          guard_m;
    logic          run_m;
    int            beat_m;
    int unsigned   m_beats;
    int unsigned   m_stalls;

    // Observation logs
    logic [DW-1:0] acc_data[$];
    logic          acc_last[$];
    int            acc_cyc[$];
    int            pop_cyc[$];

    // Per-cycle samples
    logic          exp_rd;
    logic          c_pop, c_acc, c_stall, c_flush, c_ae, c_rst, c_last;
    logic [DW-1:0] c_data;
    int            c_fsize, c_cyc;
    logic [DW-1:0] w;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty        = empty_r;
        fifo_data         = (fq.size() != 0) ? fq[0] : '0;
        fifo_almost_empty = (fq.size() <= 1);
    endtask

    task automatic model_clear();
        sb.delete();
        beat_m   = 0;
        guard_m  = 1'b0;
        run_m    = 1'b0;
        m_beats  = 0;
        m_stalls = 0;
    endtask

    task automatic clear_logs();
        acc_data.delete();
        acc_last.delete();
        acc_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
        refresh();
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc_data.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk_bit({name, "_timeout"}, acc_data.size() >= n, 1'b1);
    endtask

    // Compare at negedge, advance the model just after posedge.
    always begin
        @(negedge clk);
        cyc++;
        exp_rd = run_m && !empty_r && !guard_m && (sb.size() < 2) && !flush;
        chk_bit("rd_en", fifo_rd_en, exp_rd);
        chk_bit("stale_pop", fifo_rd_en && (fq.size() == 0), 1'b0);
        chk_bit("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            chk_word("out_data", out_data, sb[0]);
            chk_bit("out_last", out_last, beat_m == P - 1);
        end else begin
            chk_bit("out_last_idle", out_last, 1'b0);
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        chk_word("beat_count", beat_count, m_beats);
        chk_word("stall_count", stall_count, m_stalls);
`endif
        c_pop   = fifo_rd_en;
        c_acc   = (sb.size() != 0) && out_ready;
        c_stall = (sb.size() != 0) && !out_ready;
        c_flush = flush;
        c_ae    = fifo_almost_empty;
        c_rst   = reset_n;
        c_fsize = fq.size();
        c_data  = out_data;
        c_last  = out_last;
        c_cyc   = cyc;
        @(posedge clk);
        #1;
        if (!c_rst) begin
            model_clear();
        end else begin
            run_m = 1'b1;
            w = '0;
            if (c_pop) begin
                pop_cyc.push_back(c_cyc);
                if (fq.size() != 0) w = fq.pop_front();
            end
            if (c_acc) begin
                acc_data.push_back(c_data);
                acc_last.push_back(c_last);
                acc_cyc.push_back(c_cyc);
                void'(sb.pop_front());
                if (!c_flush) beat_m = (beat_m + 1) % P;
                m_beats++;
            end
            if (c_stall) m_stalls++;
            if (c_flush) begin
                sb.delete();
                beat_m = 0;
            end else if (c_pop) begin
                sb.push_back(w);
            end
            guard_m = c_pop && c_ae && !c_flush;
        end
        empty_r = (c_fsize == 0);
        refresh();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    int rel;
    int npop0;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        empty_r   = 1'b1;
        model_clear();
        clear_logs();
        load(1, 16);

        // Reset hold with a non-empty FIFO
        tick(3);
        chk_bit("rst_rd_en", fifo_rd_en, 1'b0);
        chk_bit("rst_valid", out_valid, 1'b0);
        chk_word("rst_data", out_data, '0);
        chk_bit("rst_last", out_last, 1'b0);

        // Streaming 0x1..0x10
        out_ready = 1'b1;
        clear_logs();
        rel = cyc;
        reset_n = 1'b1;
        wait_acc(16, 60, "stream");
        tick(2);
        if (pop_cyc.size() != 0) chk_int("first_pop_cycle", pop_cyc[0], rel + 2);
        if (acc_cyc.size() == 16 && pop_cyc.size() != 0) begin
            chk_int("first_beat_latency", acc_cyc[0], pop_cyc[0] + 1);
            chk_int("stream_back_to_back", acc_cyc[15], acc_cyc[0] + 15);
        end
        chk_int("stream_beats", acc_data.size(), 16);
        for (int i = 0; i < acc_data.size(); i++) begin
            chk_word("stream_word", acc_data[i], DW'(i + 1));
            chk_bit("stream_last", acc_last[i], (i % 8) == 7);
        end

        // Backpressure mid-stream
        clear_logs();
        load('h21, 16);
        tick(4);
        out_ready = 1'b0;
        npop0 = pop_cyc.size();
        tick(5);
        chk_bit("bp_pops_le2", (pop_cyc.size() - npop0) <= 2, 1'b1);
        chk_bit("bp_rd_en_off", fifo_rd_en, 1'b0);
        chk_bit("bp_valid_held", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_acc(16, 60, "bp");
        tick(2);
        chk_int("bp_beats", acc_data.size(), 16);
        for (int i = 0; i < acc_data.size(); i++) begin
            chk_word("bp_word", acc_data[i], DW'('h21 + i));
            chk_bit("bp_last", acc_last[i], (i % 8) == 7);
        end

        // Drain edge: a single word with almost_empty set
        clear_logs();
        load('h55, 1);
        tick(8);
        chk_int("drain_pops", pop_cyc.size(), 1);
        chk_int("drain_beats", acc_data.size(), 1);
        if (acc_data.size() != 0) chk_word("drain_word", acc_data[0], DW'('h55));

        // Flush with two buffered words at beat 3
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        clear_logs();
        load('h61, 16);
        wait_acc(3, 20, "flush_pre");
        out_ready = 1'b0;
        tick(2);
        chk_int("flush_pre_occ", sb.size(), 2);
        chk_int("flush_pre_beat", beat_m, 3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk_bit("flush_valid_off", out_valid, 1'b0);
        clear_logs();
        out_ready = 1'b1;
        wait_acc(11, 60, "flush_post");
        tick(2);
        chk_int("flush_post_beats", acc_data.size(), 11);
        for (int i = 0; i < acc_data.size(); i++) begin
            chk_word("flush_post_word", acc_data[i], DW'('h66 + i));
            chk_bit("flush_post_last", acc_last[i], i == 7);
        end

`ifdef FIFO_RD_STREAM_STATS_EN
        // Counters: 10 beats, 4 stall cycles, flush keeps both
        reset_n = 1'b0;
        model_clear();
        tick(3);
        chk_word("stats_rst_beats", beat_count, '0);
        chk_word("stats_rst_stalls", stall_count, '0);
        reset_n = 1'b1;
        clear_logs();
        load('h81, 10);
        wait_acc(2, 20, "stats_a");
        out_ready = 1'b0;
        tick(4);
        out_ready = 1'b1;
        wait_acc(10, 40, "stats_b");
        tick(2);
        chk_word("stats_beats", beat_count, 32'd10);
        chk_word("stats_stalls", stall_count, 32'd4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
        chk_word("stats_flush_beats", beat_count, 32'd10);
        chk_word("stats_flush_stalls", stall_count, 32'd4);
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
